// File: rtl/idex_operand_stage.sv
// ID/EX operand stage: 4x8 register file (R3 = SP), operand resolution with
// EX/MEM forwarding and write-through, load-use stall detection, IDEX register.
module idex_operand_stage #(
    parameter logic [7:0] SP_RESET = 8'hFF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       IFID_valid,
    input  logic [7:0] IFID_instr,
    input  logic [7:0] IFID_imm,
    input  logic       forward_ex_valid,
    input  logic [1:0] forward_ex_reg,
    input  logic [7:0] forward_ex_data,
    input  logic       forward_mem_valid,
    input  logic [1:0] forward_mem_reg,
    input  logic [7:0] forward_mem_data,
    input  logic       wb_we,
    input  logic [1:0] wb_reg,
    input  logic [7:0] wb_data,
    input  logic       wb_sp_we,
    input  logic [7:0] wb_sp,
    input  logic       ex_load_valid,
    input  logic [1:0] ex_load_reg,
    input  logic       flush,
    input  logic       ex_hold,
    output logic       IDEX_valid,
    output logic [3:0] IDEX_opcode,
    output logic [1:0] IDEX_ra,
    output logic [1:0] IDEX_rb,
    output logic [7:0] IDEX_a,
    output logic [7:0] IDEX_b,
    output logic [7:0] IDEX_imm,
    output logic [7:0] IDEX_sp,
    output logic       stall_ifid
);

    localparam int unsigned NREG = 4;
    localparam int unsigned DW   = 8;

    logic [DW-1:0] rf_q [NREG];
    logic [DW-1:0] rf_d [NREG];
    logic [DW-1:0] res  [NREG];

    logic          idex_valid_q,  idex_valid_d;
    logic [3:0]    idex_opcode_q, idex_opcode_d;
    logic [1:0]    idex_ra_q,     idex_ra_d;
    logic [1:0]    idex_rb_q,     idex_rb_d;
    logic [DW-1:0] idex_a_q,      idex_a_d;
    logic [DW-1:0] idex_b_q,      idex_b_d;
    logic [DW-1:0] idex_imm_q,    idex_imm_d;
    logic [DW-1:0] idex_sp_q,     idex_sp_d;

    logic [3:0] dec_opcode;
    logic [1:0] dec_ra;
    logic [1:0] dec_rb;

    assign dec_opcode = IFID_instr[7:4];
    assign dec_ra     = IFID_instr[3:2];
    assign dec_rb     = IFID_instr[1:0];

    // Next register-file contents; SP write-back overrides a GPR write to R3.
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            rf_d[i] = rf_q[i];
        end
        if (wb_we) begin
            rf_d[wb_reg] = wb_data;
        end
        if (wb_sp_we) begin
            rf_d[NREG-1] = wb_sp;
        end
    end

    // Per-register resolved value: forward EX > forward MEM > write-through > file.
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            res[i] = rf_d[i];
            if (forward_mem_valid && forward_mem_reg == 2'(i)) begin
                res[i] = forward_mem_data;
            end
            if (forward_ex_valid && forward_ex_reg == 2'(i)) begin
                res[i] = forward_ex_data;
            end
        end
    end

    // Load-use hazard against either source register; a flush cancels it.
    always_comb begin
        stall_ifid = IFID_valid & ex_load_valid
                   & ((ex_load_reg == dec_ra) | (ex_load_reg == dec_rb))
                   & ~flush;
    end

    // IDEX next state: flush > hold > bubble > load.
    always_comb begin
        idex_valid_d  = idex_valid_q;
        idex_opcode_d = idex_opcode_q;
        idex_ra_d     = idex_ra_q;
        idex_rb_d     = idex_rb_q;
        idex_a_d      = idex_a_q;
        idex_b_d      = idex_b_q;
        idex_imm_d    = idex_imm_q;
        idex_sp_d     = idex_sp_q;
        if (flush) begin
            idex_valid_d = 1'b0;
        end else if (ex_hold) begin
            idex_valid_d = idex_valid_q;
        end else if (stall_ifid) begin
            idex_valid_d = 1'b0;
        end else begin
            idex_valid_d  = IFID_valid;
            idex_opcode_d = dec_opcode;
            idex_ra_d     = dec_ra;
            idex_rb_d     = dec_rb;
            idex_a_d      = res[dec_ra];
            idex_b_d      = res[dec_rb];
            idex_imm_d    = IFID_imm;
            idex_sp_d     = res[NREG-1];
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG - 1; i++) begin
                rf_q[i] <= '0;
            end
            rf_q[NREG-1]  <= SP_RESET;
            idex_valid_q  <= 1'b0;
            idex_opcode_q <= '0;
            idex_ra_q     <= '0;
            idex_rb_q     <= '0;
            idex_a_q      <= '0;
            idex_b_q      <= '0;
            idex_imm_q    <= '0;
            idex_sp_q     <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                rf_q[i] <= rf_d[i];
            end
            idex_valid_q  <= idex_valid_d;
            idex_opcode_q <= idex_opcode_d;
            idex_ra_q     <= idex_ra_d;
            idex_rb_q     <= idex_rb_d;
            idex_a_q      <= idex_a_d;
            idex_b_q      <= idex_b_d;
            idex_imm_q    <= idex_imm_d;
            idex_sp_q     <= idex_sp_d;
        end
    end

    assign IDEX_valid  = idex_valid_q;
    assign IDEX_opcode = idex_opcode_q;
    assign IDEX_ra     = idex_ra_q;
    assign IDEX_rb     = idex_rb_q;
    assign IDEX_a      = idex_a_q;
    assign IDEX_b      = idex_b_q;
    assign IDEX_imm    = idex_imm_q;
    assign IDEX_sp     = idex_sp_q;

endmodule
